bcd_mul_seq: RTL

BCD_MUL_SEQ -- requirements
Module: bcd_mul_seq

---
 rtl/bcd_pkg.sv | 49 ++++
 rtl/bcd_mul_row.sv | 37 +++
 rtl/bcd_mul_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD multiplier definitions: FSM state type, digit width,
// default operand size, and single-digit arithmetic helpers.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int DEF_N   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mulState_t;

    // One digit times one digit, returned as two BCD digits {tens, units}.
    // Repeated subtraction of ten splits the binary product; nine passes
    // cover the largest legal product (81).
    function automatic logic [7:0] digitMul(
        input logic [3:0] x,
        input logic [3:0] y
    );
        logic [7:0] p;
        logic [3:0] t;
        p = {4'h0, x} * {4'h0, y};
        t = 4'h0;
        for (int k = 0; k < 9; k++) begin
            if (p >= 8'd10) begin
                p = p - 8'd10;
                t = t + 4'd1;
            end
        end
        return {t, p[3:0]};
    endfunction

    // One decimal digit add with carry; returns {carryOut, sumDigit}.
    // Adding 6 modulo 16 is the same as subtracting 10.
    function automatic logic [4:0] digitAdd(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'h0, cin};
        if (s > 5'd9) begin
            return {1'b1, s[3:0] + 4'd6};
        end
        return s;
    endfunction

endpackage

// File: rtl/bcd_mul_row.sv
// Combinational N-digit x 1-digit BCD product giving N+1 digits.
// Ports: aDig (N BCD digits), mDig (one BCD digit), row (N+1 digits).
module bcd_mul_row
    import bcd_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N*DIGIT_W-1:0]     aDig,
    input  logic [DIGIT_W-1:0]       mDig,
    output logic [(N+1)*DIGIT_W-1:0] row
);

    logic [7:0] pp;
    logic [4:0] s;
    logic [3:0] tens;
    logic       carry;

    // Units of digit i join the tens of digit i-1 and the running carry;
    // the sum never exceeds 18, so the carry stays a single bit.
    always_comb begin
        row   = '0;
        pp    = '0;
        s     = '0;
        tens  = '0;
        carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            pp    = digitMul(aDig[i*DIGIT_W +: DIGIT_W], mDig);
            s     = digitAdd(pp[3:0], tens, carry);
            row[i*DIGIT_W +: DIGIT_W] = s[3:0];
            carry = s[4];
            tens  = pp[7:4];
        end
        // Top digit is at most 8 + 1, so it needs no decimal correction.
        row[N*DIGIT_W +: DIGIT_W] = tens + {3'b000, carry};
    end

endmodule

// File: rtl/bcd_mul_seq.sv
// Sequential BCD multiplier: one multiplier digit per clock, MSD first.
// Ports: clk_i, rst_ni (sync, active-low), ld_i start, a_i/b_i operands,
// o_o product (view of acc), busy_o, done_o pulse, err_o bad digit.
module bcd_mul_seq
    import bcd_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ld_i,
    input  logic [N*DIGIT_W-1:0]   a_i,
    input  logic [N*DIGIT_W-1:0]   b_i,
    output logic [2*N*DIGIT_W-1:0] o_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int CW = $clog2(N);
    localparam int AW = 2 * N * DIGIT_W;

    mulState_t state;
    mulState_t stateNext;

    logic [N*DIGIT_W-1:0]     aR;
    logic [N*DIGIT_W-1:0]     bR;
    logic [AW-1:0]            acc;
    logic [AW-1:0]            accNext;
    logic [AW-1:0]            shifted;
    logic [AW-1:0]            addend;
    logic [CW-1:0]            cnt;
    logic [DIGIT_W-1:0]       curDigit;
    logic [(N+1)*DIGIT_W-1:0] row;
    logic [4:0]               s;
    logic                     carry;
    logic                     badDigit;

    assign o_o      = acc;
    assign curDigit = bR[cnt*DIGIT_W +: DIGIT_W];

    bcd_mul_row #(
        .N (N)
    ) uRow (
        .aDig (aR),
        .mDig (curDigit),
        .row  (row)
    );

    // Horner step: shift one digit left (top digit is always zero for
    // legal operands) and add the current partial-product row.
    always_comb begin
        shifted = {acc[AW-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
        addend  = {{((N-1)*DIGIT_W){1'b0}}, row};
        accNext = '0;
        s       = '0;
        carry   = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            s     = digitAdd(shifted[i*DIGIT_W +: DIGIT_W],
                             addend[i*DIGIT_W +: DIGIT_W], carry);
            accNext[i*DIGIT_W +: DIGIT_W] = s[3:0];
            carry = s[4];
        end
    end

    always_comb begin
        badDigit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (a_i[i*DIGIT_W +: DIGIT_W] > 4'd9) badDigit = 1'b1;
            if (b_i[i*DIGIT_W +: DIGIT_W] > 4'd9) badDigit = 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (ld_i) stateNext = MUL;
            MUL:     if (cnt == '0) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            aR     <= '0;
            bR     <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            state  <= stateNext;
            busy_o <= (stateNext != IDLE);
            done_o <= (state == MUL) && (cnt == '0);
            unique case (state)
                IDLE: begin
                    if (ld_i) begin
                        aR    <= a_i;
                        bR    <= b_i;
                        acc   <= '0;
                        cnt   <= CW'(N - 1);
                        err_o <= badDigit;
                    end
                end
                MUL: begin
                    acc <= accNext;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
